multi_channel_edge_detector: RTL and testbench
==============================================

// Module: multi_channel_edge_detector
// PURPOSE
//   Parametrised successor to the single-channel falling-edge start detector. Each channel
//   synchronises one asynchronous input, rejects glitches shorter than FILTER_CYCLES,
//   and emits a one-cycle pulse on a qualified rising, falling or either edge.
//   Sticky status and overrun flags are kept per channel. Sits between the pads and the
//   I2C/protocol front-ends: START/STOP detection, SCL/SDA edge qualification, wake events.
// PARAMETERS
//   CHANNELS       4   number of independent input channels (>=1)
//   SYNC_STAGES    2   flip-flops in each input synchroniser (>=2)
//   FILTER_CYCLES  4   consecutive stable synced samples to accept a new level (>=1)
// PORTS
//   clock         in   1            single clock, all logic on posedge
//   reset         in   1            synchronous, active-high reset
//   enable        in   1            0: all channels held in IDLE, outputs forced 0
//   data_in       in   CHANNELS     asynchronous raw inputs
//   mode          in   2*CHANNELS   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   status_clear  in   CHANNELS     per channel: clear status and overrun
//   pulse_out     out  CHANNELS     one-cycle pulse per qualified enabled edge
//   level_out     out  CHANNELS     filtered (debounced) level; 0 while IDLE
//   status        out  CHANNELS     sticky: set by pulse_out
//   overrun       out  CHANNELS     sticky: pulse while status already set
// BEHAVIOUR
//   - Reset: all sync flops, counters, pulse_out, level_out, status and overrun = 0. FSM = IDLE.
//     Reset mid-qualification aborts it. No pulse is produced for the edge that led to the reset.
//   - Per-channel FSM on synced input s, with counter cnt of width $clog2(FILTER_CYCLES+1):
//       IDLE   : baseline. cnt counts consecutive equal samples and restarts on change.
//                At FILTER_CYCLES, go to ST_LOW or ST_HIGH. No pulse.
//       ST_LOW : if s=1, go to Q_HIGH with cnt=1.        ST_HIGH: if s=0, go to Q_LOW with cnt=1.
//       Q_HIGH : if s=0, return to ST_LOW (glitch dropped, no pulse). Otherwise cnt++.
//                When cnt reaches FILTER_CYCLES, go to ST_HIGH and pulse if mode[0].
//       Q_LOW  : mirror of Q_HIGH. Completion goes to ST_LOW and pulses if mode[1].
//     With FILTER_CYCLES=1, the Q states complete on entry (no dwell).
//   - level_out: 1 in ST_HIGH and Q_LOW; 0 in ST_LOW, Q_HIGH and IDLE.
//     It updates in the same cycle as the pulse.
//   - Latency: data_in changes and is held. pulse_out is high for exactly one cycle, at the
//     SYNC_STAGES+FILTER_CYCLES-th posedge after the first posedge that samples the new value
//     (6 with defaults). Back-to-back qualified edges give separate pulses.
//   - mode is sampled when a qualification completes. Mode changes never disturb the FSM.
//     mode=00 still tracks level_out.
//   - enable=0: FSM is forced to IDLE every cycle, and pulse_out/level_out read 0.
//     Synchronisers keep running. status and overrun hold their values.
//     Re-enable re-baselines without a pulse.
//   - status[i]: set when pulse_out[i]=1; cleared by status_clear[i].
//     If set and clear occur in the same cycle, set wins.
//   - overrun[i]: set when pulse_out[i]=1 while status[i]=1 and status_clear[i]=0.
//     Cleared by status_clear[i]. If pulse and clear occur in the same cycle, overrun is not set.
//   - Channels are fully independent. Simultaneous edges on several channels all pulse in
//     the same cycle.
// STRUCTURE
//   - Package edge_detector_pkg: mode encodings (MODE_OFF/RISE/FALL/BOTH) and FSM state
//     localparams (3-bit: IDLE, ST_LOW, ST_HIGH, Q_HIGH, Q_LOW).
//   - Sub-module edge_detect_channel: one synchroniser, FSM, counter, pulse, level,
//     status and overrun. The top level is a generate loop over CHANNELS plus bus slicing.
//   - Unused FSM encodings recover to IDLE; do not propagate X.
// TESTING
//   1. Reset and baseline: reset=1 for 2 cycles, data_in=4'b0101 held, enable=1 ->
//      outputs 0 throughout. level_out=0101 after 6 cycles. No pulse ever.
//   2. Latency: ch0 mode=01, raise data_in[0] -> pulse_out[0] high for exactly 1 cycle at
//      edge 6. status[0]=1. Lowering with mode=01 -> no pulse, level_out[0]=0.
//   3. Glitch: ch1 stable high, mode=10, 3-cycle low glitch -> no pulse, level_out[1] stays 1.
//      A 4-cycle low -> one pulse.
//   4. Both-edge and overrun: ch2 mode=11, toggle every 10 cycles x2 -> two pulses.
//      status[2]=1, overrun[2]=1. status_clear[2] -> both 0 next cycle.
//   5. Set/clear collision: assert status_clear[3] on the pulse cycle -> status[3]=1,
//      overrun[3]=0.
//   6. Enable and reset mid-qualification: drop enable, or assert reset, 2 cycles into Q_HIGH
//      -> no pulse. Re-enable with input high -> level_out=1 after FILTER_CYCLES, no pulse.

Source files
------------

// File: rtl/edge_detector_pkg.sv
// Shared encodings for the multi-channel edge detector: edge-select modes and
// the per-channel qualification FSM states.
package edge_detector_pkg;

   localparam int MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
   localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
   localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ST_LOW  = 3'd1,
      ST_HIGH = 3'd2,
      Q_HIGH  = 3'd3,
      Q_LOW   = 3'd4
   } state_t;

   function automatic logic pulse_on_rise(input logic [MODE_W-1:0] m);
      return (m == MODE_RISE) || (m == MODE_BOTH);
   endfunction

   function automatic logic pulse_on_fall(input logic [MODE_W-1:0] m);
      return (m == MODE_FALL) || (m == MODE_BOTH);
   endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: input synchroniser, debounce/qualification FSM, edge pulse,
// filtered level, and sticky status/overrun flags.
module edge_detect_channel
   import edge_detector_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              din,
   input  logic [MODE_W-1:0] mode,
   input  logic              status_clear,
   output logic              pulse_out,
   output logic              level_out,
   output logic              status,
   output logic              overrun
);

   localparam int              CW     = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0]   FILT   = CW'(FILTER_CYCLES);
   localparam logic [CW-1:0]   ONE    = CW'(1);
   localparam bit              SINGLE = (FILTER_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_inc;
   logic [CW-1:0]          idle_cnt;
   logic                   last;
   logic                   pulse_q;
   logic                   level_q;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], din};
   end

   assign s        = sync[SYNC_STAGES-1];
   assign cnt_inc  = cnt + ONE;
   assign idle_cnt = ((cnt == '0) || (s != last)) ? ONE : cnt_inc;

   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         state   <= IDLE;
         cnt     <= '0;
         last    <= 1'b0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state)
            IDLE: begin
               last <= s;
               if (idle_cnt == FILT) begin
                  state   <= s ? ST_HIGH : ST_LOW;
                  level_q <= s;
                  cnt     <= '0;
               end else begin
                  cnt <= idle_cnt;
               end
            end
            ST_LOW: if (s) begin
               if (SINGLE) begin
                  state   <= ST_HIGH;
                  level_q <= 1'b1;
                  pulse_q <= pulse_on_rise(mode);
               end else begin
                  state <= Q_HIGH;
                  cnt   <= ONE;
               end
            end
            ST_HIGH: if (!s) begin
               if (SINGLE) begin
                  state   <= ST_LOW;
                  level_q <= 1'b0;
                  pulse_q <= pulse_on_fall(mode);
               end else begin
                  state <= Q_LOW;
                  cnt   <= ONE;
               end
            end
            Q_HIGH: begin
               if (!s) begin
                  state <= ST_LOW;
                  cnt   <= '0;
               end else if (cnt_inc == FILT) begin
                  state   <= ST_HIGH;
                  level_q <= 1'b1;
                  pulse_q <= pulse_on_rise(mode);
                  cnt     <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            Q_LOW: begin
               if (s) begin
                  state <= ST_HIGH;
                  cnt   <= '0;
               end else if (cnt_inc == FILT) begin
                  state   <= ST_LOW;
                  level_q <= 1'b0;
                  pulse_q <= pulse_on_fall(mode);
                  cnt     <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign pulse_out = pulse_q & enable;
   assign level_out = level_q & enable;

   // Set beats clear for status; a clear in the pulse cycle suppresses overrun.
   always_ff @(posedge clock) begin
      if (reset) begin
         status  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         status  <= pulse_out | (status & ~status_clear);
         overrun <= (pulse_out & status & ~status_clear) | (overrun & ~status_clear);
      end
   end

endmodule

// File: rtl/multi_channel_edge_detector.sv
// Multi-channel edge detector: an array of independent qualification channels
// sharing clock, reset and enable.
module multi_channel_edge_detector
   import edge_detector_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [CHANNELS-1:0]        data_in,
   input  logic [MODE_W*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]        status_clear,
   output logic [CHANNELS-1:0]        pulse_out,
   output logic [CHANNELS-1:0]        level_out,
   output logic [CHANNELS-1:0]        status,
   output logic [CHANNELS-1:0]        overrun
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_detect_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES)
      ) u_ch (
         .clock        (clock),
         .reset        (reset),
         .enable       (enable),
         .din          (data_in[i]),
         .mode         (mode[MODE_W*i +: MODE_W]),
         .status_clear (status_clear[i]),
         .pulse_out    (pulse_out[i]),
         .level_out    (level_out[i]),
         .status       (status[i]),
         .overrun      (overrun[i])
      );
   end

endmodule

// File: tb/tb_multi_channel_edge_detector.sv
// Directed bench for multi_channel_edge_detector with default parameters
// (4 channels, 2 sync stages, filter of 4: pulse at the 6th edge after a change).
module tb_multi_channel_edge_detector;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [3:0] data_in;
   logic [7:0] mode;
   logic [3:0] status_clear;
   logic [3:0] pulse_out;
   logic [3:0] level_out;
   logic [3:0] status;
   logic [3:0] overrun;

   int checks   = 0;
   int failures = 0;

   multi_channel_edge_detector dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .data_in      (data_in),
      .mode         (mode),
      .status_clear (status_clear),
      .pulse_out    (pulse_out),
      .level_out    (level_out),
      .status       (status),
      .overrun      (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Ticks edges from..to after a stimulus change; pulse_out must equal exp at edge 'at', else 0.
   task automatic watch(input string tag, input int from, input int to, input int at,
                        input logic [3:0] exp);
      for (int t = from; t <= to; t++) begin
         tick();
         chk($sformatf("%s pulse@%0d", tag, t), pulse_out, (t == at) ? exp : 4'b0000);
      end
   endtask

   initial begin
      reset        = 1'b1;
      enable       = 1'b1;
      data_in      = 4'b0101;
      mode         = 8'b00_00_00_00;
      status_clear = 4'b0000;

      // 1. reset and baseline
      tick();
      chk("rst pulse", pulse_out, 4'b0000);
      chk("rst level", level_out, 4'b0000);
      tick();
      chk("rst status", status, 4'b0000);
      chk("rst overrun", overrun, 4'b0000);
      reset = 1'b0;
      watch("base", 1, 5, 0, 4'b0000);
      chk("base level@5", level_out, 4'b0000);
      watch("base", 6, 6, 0, 4'b0000);
      chk("base level@6", level_out, 4'b0101);
      watch("base", 7, 8, 0, 4'b0000);
      chk("base status", status, 4'b0000);

      // ch3=rise, ch2=both, ch1=fall, ch0=rise
      mode = 8'b01_11_10_01;

      // 2. latency: ch0 fall with rise-only mode, then rise
      data_in = 4'b0100;
      watch("ch0 fall", 1, 5, 0, 4'b0000);
      chk("ch0 fall level@5", level_out, 4'b0101);
      watch("ch0 fall", 6, 8, 0, 4'b0000);
      chk("ch0 fall level", level_out, 4'b0100);
      data_in = 4'b0101;
      watch("ch0 rise", 1, 5, 0, 4'b0000);
      chk("ch0 rise level@5", level_out, 4'b0100);
      watch("ch0 rise", 6, 6, 6, 4'b0001);
      chk("ch0 rise level@6", level_out, 4'b0101);
      watch("ch0 rise", 7, 7, 0, 4'b0000);
      chk("ch0 status", status, 4'b0001);
      chk("ch0 overrun", overrun, 4'b0000);

      // 3. glitch rejection on ch1 (fall mode)
      data_in = 4'b0111;
      watch("ch1 rise", 1, 8, 0, 4'b0000);
      chk("ch1 high level", level_out, 4'b0111);
      data_in = 4'b0101;
      watch("ch1 glitch3", 1, 3, 0, 4'b0000);
      data_in = 4'b0111;
      watch("ch1 glitch3", 4, 5, 0, 4'b0000);
      chk("ch1 glitch level mid", level_out, 4'b0111);
      watch("ch1 glitch3", 6, 10, 0, 4'b0000);
      chk("ch1 glitch level", level_out, 4'b0111);
      data_in = 4'b0101;
      watch("ch1 low4", 1, 4, 0, 4'b0000);
      data_in = 4'b0111;
      watch("ch1 low4", 5, 12, 6, 4'b0010);
      chk("ch1 level after", level_out, 4'b0111);
      chk("ch1 status", status, 4'b0011);
      chk("ch1 overrun", overrun, 4'b0000);

      // 4. both edges and overrun on ch2
      data_in = 4'b0011;
      watch("ch2 fall", 1, 10, 6, 4'b0100);
      chk("ch2 level low", level_out, 4'b0011);
      chk("ch2 overrun first", overrun, 4'b0000);
      data_in = 4'b0111;
      watch("ch2 rise", 1, 10, 6, 4'b0100);
      chk("ch2 status", status, 4'b0111);
      chk("ch2 overrun", overrun, 4'b0100);
      status_clear = 4'b0100;
      tick();
      status_clear = 4'b0000;
      chk("ch2 clr status", status, 4'b0011);
      chk("ch2 clr overrun", overrun, 4'b0000);

      // 5. set/clear collision on ch3 (rise mode), first with status clear, then set
      data_in = 4'b1111;
      watch("ch3 rise1", 1, 6, 6, 4'b1000);
      status_clear = 4'b1000;
      tick();
      status_clear = 4'b0000;
      chk("ch3 coll1 pulse", pulse_out, 4'b0000);
      chk("ch3 coll1 status", status, 4'b1011);
      chk("ch3 coll1 overrun", overrun, 4'b0000);
      data_in = 4'b0111;
      watch("ch3 fall", 1, 8, 0, 4'b0000);
      data_in = 4'b1111;
      watch("ch3 rise2", 1, 6, 6, 4'b1000);
      status_clear = 4'b1000;
      tick();
      status_clear = 4'b0000;
      chk("ch3 coll2 status", status, 4'b1011);
      chk("ch3 coll2 overrun", overrun, 4'b0000);

      // 6a. enable drop two cycles into Q_HIGH on ch0
      data_in = 4'b1110;
      watch("ch0 fall2", 1, 8, 0, 4'b0000);
      data_in = 4'b1111;
      watch("ch0 qual", 1, 4, 0, 4'b0000);
      enable = 1'b0;
      watch("dis", 5, 9, 0, 4'b0000);
      chk("dis level", level_out, 4'b0000);
      chk("dis status held", status, 4'b1011);
      enable = 1'b1;
      watch("reen", 1, 3, 0, 4'b0000);
      chk("reen level@3", level_out, 4'b0000);
      watch("reen", 4, 4, 0, 4'b0000);
      chk("reen level@4", level_out, 4'b1111);
      watch("reen", 5, 8, 0, 4'b0000);
      chk("reen status", status, 4'b1011);

      // 6b. reset two cycles into Q_HIGH on ch0
      data_in = 4'b1110;
      watch("ch0 fall3", 1, 8, 0, 4'b0000);
      data_in = 4'b1111;
      watch("ch0 qual2", 1, 4, 0, 4'b0000);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("mid rst level", level_out, 4'b0000);
      chk("mid rst status", status, 4'b0000);
      watch("post rst", 1, 5, 0, 4'b0000);
      chk("post rst level@5", level_out, 4'b0000);
      watch("post rst", 6, 8, 0, 4'b0000);
      chk("post rst level", level_out, 4'b1111);
      chk("post rst status", status, 4'b0000);
      chk("post rst overrun", overrun, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
